// File: rtl/sec32_pkg.sv
// Shared constants, check-bit masks and codeword type for the 32-bit SEC encoder/decoder pair.
package sec32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHK_W  = 8;

    // CHK_MASK[k] selects the data bits whose XOR forms check bit c[k].
    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        32'h8888_F0F0,  // c7
        32'h4444_0F0F,  // c6
        32'h2222_FF00,  // c5
        32'h1111_00FF,  // c4
        32'hF0F0_8888,  // c3
        32'h0F0F_4444,  // c2
        32'hFF00_2222,  // c1
        32'h00FF_1111   // c0
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CHK_W-1:0]  chk;
    } sec32_cw_t;

endpackage

// File: rtl/sec32_parity.sv
// Combinational check-byte generator; also serves as the decoder's reference model.
module sec32_parity
    import sec32_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CHK_W-1:0]  o_chk
);

    always_comb begin
        o_chk = '0;
        for (int unsigned k = 0; k < CHK_W; k++) begin
            o_chk[k] = ^(i_data & CHK_MASK[k]);
        end
    end

endmodule

// File: rtl/sec32_encoder.sv
// Two-stage valid/ready SEC encoder: 32-bit data in, data plus 8-bit check byte out,
// with optional single check-bit corruption for decoder testing.
module sec32_encoder
    import sec32_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_en,
    input  logic [2:0]        inj_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_chk,
    output logic [CNT_W-1:0]  word_cnt
);

    logic              w_s2_ready;
    logic              w_accept;
    logic [CHK_W-1:0]  w_par;
    logic [CHK_W-1:0]  w_inj_mask;

    logic              r_s1_v;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_par;
    logic              r_s1_inj;
    logic [2:0]        r_s1_sel;

    logic              r_s2_v;
    sec32_cw_t         r_s2_cw;
    logic [CNT_W-1:0]  r_cnt;

    sec32_parity u_parity (
        .i_data (in_data),
        .o_chk  (w_par)
    );

    // Ready only looks at stage occupancy and out_ready, never at in_valid.
    assign w_s2_ready = !r_s2_v || out_ready;
    assign in_ready   = !r_s1_v || w_s2_ready;
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_inj_mask = '0;
        if (r_s1_inj) begin
            w_inj_mask[r_s1_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_par  <= '0;
            r_s1_inj  <= 1'b0;
            r_s1_sel  <= '0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_par  <= w_par;
                r_s1_inj  <= inj_en;
                r_s1_sel  <= inj_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v  <= 1'b0;
            r_s2_cw <= '0;
        end else if (w_s2_ready) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_cw.data <= r_s1_data;
                r_s2_cw.chk  <= r_s1_par ^ w_inj_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_s2_v && out_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_v;
    assign out_data  = r_s2_cw.data;
    assign out_chk   = r_s2_cw.chk;
    assign word_cnt  = r_cnt;

endmodule

// File: doc/sec32_encoder.md
SEC32_ENCODER -- requirements
Module: sec32_encoder

Interface
REQ-001 CNT_W, 16, width of the encoded-word counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-high.
REQ-004 in_valid  in  1  input word valid.
REQ-005 in_ready  out  1  block accepts input word this cycle.
REQ-006 in_data  in  32  data word; bit i is d[i].
REQ-007 inj_en  in  1  sampled with accepted word; when 1, corrupt the check bit selected by inj_sel.
REQ-008 inj_sel  in  3  check-bit index to invert when inj_en=1.
REQ-009 out_valid  out  1  codeword valid.
REQ-010 out_ready  in  1  downstream accepts codeword.
REQ-011 out_data  out  32  data word passed through unmodified.
REQ-012 out_chk  out  8  check byte c[7:0].
REQ-013 word_cnt  out  CNT_W  count of codewords delivered (out_valid AND out_ready).

Function
REQ-014 The check bits SHALL make the matching 32-bit SEC decoder syndrome zero: c0 = xor d{0,4,8,12,16..23}; c1 = xor d{1,5,9,13,24..31}; c2 = xor d{2,6,10,14,16..19,24..27}; c3 = xor d{3,7,11,15,20..23,28..31}.
REQ-015 c4 = xor d{16,20,24,28,0..7}; c5 = xor d{17,21,25,29,8..15}; c6 = xor d{18,22,26,30,0..3,8..11}; c7 = xor d{19,23,27,31,4..7,12..15}.
REQ-016 Two-stage pipeline: stage 1 registers data, the eight nibble parities and the injection controls; stage 2 registers out_data/out_chk.
REQ-017 Latency SHALL be exactly 2 cycles from accept (in_valid AND in_ready) to out_valid with no backpressure.
REQ-018 Each stage SHALL load when empty or when its contents move forward in the same cycle; in_ready = NOT stage1_valid OR stage1 advancing.
REQ-019 in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 Full throughput: one word per cycle while out_ready=1.
REQ-021 out_ready=0 with both stages full: in_ready=0; out_data/out_chk/out_valid held stable until out_ready=1.
REQ-022 No word dropped, duplicated or reordered under any valid/ready pattern.
REQ-023 inj_en=1: out_chk SHALL equal the REQ-014/015 value with bit inj_sel inverted; out_data is never corrupted.
REQ-024 word_cnt SHALL increment by 1 per delivered word and wrap from 2^CNT_W-1 to 0.
REQ-025 in_valid without acceptance is ignored; in_data may change while in_ready=0.

Reset
REQ-026 While rst=1: both stage valids, out_valid, out_data, out_chk and word_cnt = 0; in_ready = 1 once rst deasserts.
REQ-027 Reset mid-operation SHALL discard in-flight words; the first word accepted after reset appears 2 cycles later.

Structure
REQ-028 Package sec32_pkg SHALL hold the eight 32-bit check-bit masks, data/check width constants and a codeword struct (data, chk).
REQ-029 One sub-module sec32_parity (combinational, 32-bit data to 8 check bits via the package masks) SHALL be used; the decoder bench reuses it as the reference model.

Verification
REQ-030 in_data 0x00000000 and 0xFFFFFFFF -> out_chk 0x00 for both, 2 cycles after accept.
REQ-031 Walking one: 0x00000001 -> 0x51; 0x00010000 -> 0x15; 0x80000000 -> 0x8A; all 32 positions match sec32_parity.
REQ-032 Back-to-back 8 random words, out_ready toggled 1,0,0,1,... -> identical ordered output, in_ready=0 exactly while both stages are full and out_ready=0.
REQ-033 inj_en=1, inj_sel=3, data 0x00000001 -> out_chk 0x59; the decoder corrects it back to 0x00000001.
REQ-034 Assert rst with 2 words in flight -> out_valid=0 and word_cnt=0 immediately; no stale word after release.
REQ-035 CNT_W=4, deliver 17 words -> word_cnt = 1.
